// File: rtl/apb_rr_pkg.sv
// Shared types and helpers for the round-robin APB master.
package apb_rr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT = 16;

    // Successor of idx in a ring of n requesters.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/apb_rr_master_if.sv
// APB signal set shared by the master and the slave side.
interface apb_rr_master_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pwrite;
    logic              psel;
    logic              penable;
    logic              pready;
    logic              pslverr;

    // Transfer handshake: psel opens it, penable marks ACCESS, pready closes it.
    modport master (
        output paddr, pwdata, pwrite, psel, penable,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwdata, pwrite, psel, penable,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_rr_master_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating start pointer.
module rr_arbiter
    import apb_rr_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd_en,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any
);
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    // ptr_q is the first index searched; it moves to one past the winner.
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx, win;

    always_comb begin
        gnt = '0;
        any = 1'b0;
        win = ptr_q;
        idx = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                win      = idx;
            end
            idx = IDX_W'(rr_next(32'(idx), NUM_REQ));
        end
        ptr_d = ptr_q;
        if (upd_en && any) begin
            ptr_d = IDX_W'(rr_next(32'(win), NUM_REQ));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sharing one bus between NUM_REQ requesters, round-robin, with
// an ACCESS wait-state timeout.
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output state_t                    dbg_state,
    apb_rr_master_if.master           apb
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                pwrite_q, pwrite_d;
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  arb_gnt;
    logic                arb_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_valid),
        .upd_en (state_q == IDLE),
        .gnt    (arb_gnt),
        .any    (arb_any)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        cnt_d       = cnt_q;
        req_ready_d = '0;
        rsp_valid_d = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d     = SETUP;
                    gnt_d       = arb_gnt;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    req_ready_d = arb_gnt;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (arb_gnt[i]) begin
                            paddr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            pwdata_d = req_wdata[i*DATA_W +: DATA_W];
                            pwrite_d = req_write[i];
                        end
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            ACCESS: begin
                if (apb.pready) begin
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = gnt_q;
                    rsp_rdata_d = pwrite_q ? '0 : apb.prdata;
                    rsp_err_d   = apb.pslverr;
                end else if (cnt_q >= CNT_LAST) begin
                    // Hung slave: give up after TIMEOUT ACCESS cycles.
                    state_d     = IDLE;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = gnt_q;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            req_ready_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- APB master that shares one APB bus between NUM_REQ local requesters, using round-robin arbitration.
- Latches the winning request and runs the APB SETUP/ACCESS sequence.
- Returns read data or error to the granted requester.
- Includes a wait-state timeout so a hung slave cannot lock up the bus.
- Sits between requester-side logic (test bench drivers, DMA-style engines) and the apb_if signal set.

Parameters:
- NUM_REQ, 2: number of requesters (2..8).
- ADDR_W, 32: paddr width.
- DATA_W, 32: pwdata/prdata width.
- TIMEOUT, 16: maximum ACCESS cycles waiting for pready before abort (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request; held until req_ready seen.
- req_write  in  NUM_REQ  per-requester direction, 1 = write.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid with rsp_valid. Write or timeout gives 0.
- rsp_err  out  1  pslverr or timeout; valid with rsp_valid.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- All outputs are registered. Reset drives every output to 0, state to IDLE, and the round-robin pointer to 0. Reset takes effect immediately, including mid-transfer: psel/penable drop at once, and no rsp_valid is issued for the aborted transfer.
- States: IDLE, SETUP, ACCESS.
- IDLE, with any req_valid:
  - Grant the first set bit searching from (last_grant+1) mod NUM_REQ, wrapping.
  - Latch addr, wdata and write for the winner; update last_grant.
  - Go to SETUP.
- IDLE, with no req_valid: stay in IDLE.
- SETUP (exactly 1 cycle):
  - psel=1, penable=0, paddr/pwdata/pwrite = latched values.
  - req_ready[grant]=1 for this cycle only.
  - Go to ACCESS; clear the wait counter.
- ACCESS:
  - psel=1, penable=1; paddr/pwdata/pwrite stay stable.
  - pready=1: capture prdata (reads only, else 0) and pslverr. Go to IDLE. In the next cycle rsp_valid[grant]=1 with the captured rsp_rdata/rsp_err.
  - pready=0: increment the wait counter. When the counter reaches TIMEOUT-1 with pready still 0, abort: rsp_rdata=0, rsp_err=1, go to IDLE with the same rsp_valid timing.
- Leaving ACCESS clears psel and penable in the same edge.
- Minimum transfer = 3 cycles (IDLE, SETUP, ACCESS). Back-to-back requests therefore pass through one IDLE cycle, which is also the rsp_valid cycle.
- Requests arriving during SETUP/ACCESS are not sampled. The requester already granted must drop or change req_valid after req_ready, otherwise it is treated as a new request.
- A requester changing its req_* fields after req_ready has no effect on the transfer in flight.
- With a single active requester, it is granted every transfer. With all requesters active, grants rotate 0,1,..,NUM_REQ-1,0.
- Wait counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

Decomposition:
- Package apb_rr_pkg:
  - state_t enum {IDLE, SETUP, ACCESS}.
  - Localparam for default TIMEOUT.
  - Helper function for the next round-robin index.
- Sub-module rr_arbiter: combinational one-hot grant from req_valid and a last_grant register (NUM_REQ parameter). Pointer update is enabled by the FSM only in IDLE on grant.

Test Plan:
- Single write: requester 0 writes addr 0x10, data 0xA5, slave pready=1 in the first ACCESS cycle. Expect psel high for 2 cycles, penable in the 2nd, req_ready[0] in SETUP, rsp_valid[0] next cycle with rsp_err=0 and rsp_rdata=0.
- Read with wait states: requester 1 reads 0x20, pready after 3 ACCESS cycles with prdata 0xDEADBEEF. Expect paddr stable throughout, then rsp_rdata 0xDEADBEEF and rsp_valid[1].
- Round-robin: both requesters hold req_valid for 4 transfers. Expect grant order 0,1,0,1 and paddr alternating per latched address.
- Timeout: pready held 0 with TIMEOUT=16. Expect ACCESS to last exactly 16 cycles, then rsp_err=1, rsp_rdata=0, psel=0.
- Slave error: pslverr=1 with pready. Expect rsp_err=1 on rsp_valid.
- Reset mid-ACCESS: assert rst during a wait state. Expect psel/penable low immediately, no rsp_valid, and the pointer reset so the next grant goes to requester 0 when both request.
